// File: rtl/sr_trace_tx.sv
// Trace transmitter for the schoolRISCV core: buffers {miss, a0, instr, pc} samples
// in a small FIFO and sends each one as a 14-byte 8N1 UART frame.
module sr_trace_tx #(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trcValid,
    input  logic [31:0] trcPc,
    input  logic [31:0] trcInstr,
    input  logic [31:0] trcA0,
    input  logic        trcMiss,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef struct packed {
        logic        miss;
        logic [31:0] a0;
        logic [31:0] instr;
        logic [31:0] pc;
    } sample_t;

    typedef enum logic {IDLE, SEND} state_t;

    sample_t         mem [DEPTH];
    sample_t         head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            drop_pending;
    state_t          state, state_next;
    logic            push, pop, drop, frame_end;
    logic [CW-1:0]   bit_cnt;
    logic [3:0]      bit_idx, byte_idx;
    logic [13:0][7:0] frame;
    logic [7:0]      cur_byte;

    // A full FIFO drops the sample even if the serializer pops on the same edge.
    assign push      = trcValid && (count != FULL);
    assign drop      = trcValid && (count == FULL);
    assign head      = mem[rd_ptr];
    assign cur_byte  = frame[byte_idx];
    assign frame_end = (state == SEND) && (bit_cnt == CNT_LAST) &&
                       (bit_idx == 4'd9) && (byte_idx == 4'd13);
    assign busy      = (count != '0) || (state == SEND);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{miss: trcMiss, a0: trcA0, instr: trcInstr, pc: trcPc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            drop_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                drop_pending <= 1'b1;
                overflow     <= 1'b1;
            end else if (pop) begin
                drop_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Popping at the end of the last stop bit keeps frames gapless.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop        = 1'b1;
                state_next = SEND;
            end
            SEND: if (frame_end) begin
                if (count != '0) pop = 1'b1;
                else             state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
        end else if (pop) begin
            frame    <= {6'b0, drop_pending, head.miss, head.a0, head.instr, head.pc, 8'hA5};
            tx       <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else if (state == SEND) begin
            if (bit_cnt != CNT_LAST) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    bit_idx <= '0;
                    if (byte_idx == 4'd13) begin
                        tx <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        tx       <= 1'b0;
                    end
                end else begin
                    // Next wire bit is bit_idx+1: data bit bit_idx, or stop after bit 7.
                    bit_idx <= bit_idx + 1'b1;
                    tx      <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                end
            end
        end
    end
endmodule

// File: tb/tb_sr_trace_tx.sv
// Directed bench for sr_trace_tx: a UART frame sampler checks frame contents,
// latency, contiguity, overflow behaviour and asynchronous reset.
module tb_sr_trace_tx;
    localparam int DEPTH     = 4;
    localparam int CLK_DIV   = 4;
    localparam int FRAME_CYC = 140 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trcValid = 1'b0;
    logic        trcMiss = 1'b0;
    logic [31:0] trcPc = '0, trcInstr = '0, trcA0 = '0;
    logic        tx, busy, overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_edge = 0;

    sr_trace_tx #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .trcValid(trcValid), .trcPc(trcPc),
        .trcInstr(trcInstr), .trcA0(trcA0), .trcMiss(trcMiss),
        .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  instr;
        logic [31:0]  a0;
        logic         miss;
        logic [111:0] exp;   // byte 0 of the frame in the top byte
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [111:0] mk(input logic [31:0] pc, input logic [31:0] instr,
                                        input logic [31:0] a0, input logic [7:0] fl);
        return {8'hA5, bs(pc), bs(instr), bs(a0), fl};
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] a0, input logic miss);
        @(negedge clk);
        trcValid = 1'b1;
        trcPc    = pc;
        trcInstr = instr;
        trcA0    = a0;
        trcMiss  = miss;
        push_edge = cyc + 1;
    endtask

    task automatic idle();
        @(negedge clk);
        trcValid = 1'b0;
    endtask

    // Waits for a start bit, then samples all 140 bits mid-bit at fixed offsets.
    task automatic recv_frame(output logic [111:0] f, output logic ok, output int det);
        logic [139:0] bits;
        int n;
        n = 0;
        f = '0;
        ok = 1'b0;
        det = -1;
        bits = '0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 3000);
        if (tx !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout actual=no_start_bit required=start_bit");
        end else begin
            det = cyc;
            repeat (CLK_DIV / 2) @(negedge clk);
            bits[0] = tx;
            for (int b = 1; b < 140; b++) begin
                repeat (CLK_DIV) @(negedge clk);
                bits[b] = tx;
            end
            ok = 1'b1;
            for (int i = 0; i < 14; i++) begin
                if (bits[10*i] !== 1'b0 || bits[10*i+9] !== 1'b1) ok = 1'b0;
                for (int j = 0; j < 8; j++) f[104 - 8*i + j] = bits[10*i + 1 + j];
            end
        end
    endtask

    task automatic wait_idle(input string name, input int start, input int len);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, cyc - start, len);
    endtask

    logic [111:0] f, f2;
    logic         ok, ok2;
    int           det, det2, bad;
    logic [111:0] fr[5];
    logic         frok[5];

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h0050_0513, 32'h0000_0005, 1'b0,
                    112'hA5_10000000_13055000_05000000_00};
        vecs[1] = '{32'h0000_0010, 32'h0050_0513, 32'h0000_0005, 1'b1,
                    112'hA5_10000000_13055000_05000000_01};
        vecs[2] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1,
                    112'hA5_78563412_EFBEADDE_FFFFFFFF_01};
        vecs[3] = '{32'h8000_0004, 32'h0000_006F, 32'h0000_0000, 1'b0,
                    112'hA5_04000080_6F000000_00000000_00};

        // Reset held for 3 cycles, then a quiet interval
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_during", {tx, busy, overflow}, 3'b100);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_after", {tx, busy, overflow}, 3'b100);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single-sample frames
        for (int i = 0; i < 4; i++) begin
            fork
                begin
                    push(vecs[i].pc, vecs[i].instr, vecs[i].a0, vecs[i].miss);
                    idle();
                end
                recv_frame(f, ok, det);
            join
            chk($sformatf("frame%0d", i), f, vecs[i].exp);
            chk($sformatf("framing%0d", i), ok, 1'b1);
            chk($sformatf("latency%0d", i), det - push_edge, 1);
            wait_idle($sformatf("busy_len%0d", i), det, FRAME_CYC);
        end

        // Back-to-back frames are contiguous
        fork
            begin
                push(vecs[0].pc, vecs[0].instr, vecs[0].a0, vecs[0].miss);
                push(vecs[2].pc, vecs[2].instr, vecs[2].a0, vecs[2].miss);
                idle();
            end
            begin
                recv_frame(f, ok, det);
                recv_frame(f2, ok2, det2);
            end
        join
        chk("b2b_frame1", f, vecs[0].exp);
        chk("b2b_frame2", f2, vecs[2].exp);
        chk("b2b_framing", {ok, ok2}, 2'b11);
        chk("b2b_gap", det2 - det, FRAME_CYC);
        wait_idle("b2b_total", det, 2 * FRAME_CYC);

        // Six samples on consecutive edges: the sixth is dropped
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    push(32'h100 + 4*i, 32'h1000 + i, 32'hA0 + i, 1'b0);
                    if (i == 6) chk("ovf_before", overflow, 1'b0);
                end
                idle();
                chk("ovf_set", overflow, 1'b1);
            end
            for (int k = 0; k < 5; k++) begin
                recv_frame(f, ok, det);
                fr[k] = f;
                frok[k] = ok;
            end
        join
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ovf_frame%0d", k + 1), fr[k],
                mk(32'h100 + 4*(k+1), 32'h1000 + k + 1, 32'hA0 + k + 1, (k == 1) ? 8'h02 : 8'h00));
            chk($sformatf("ovf_framing%0d", k + 1), frok[k], 1'b1);
        end
        wait_idle("ovf_last_len", det, FRAME_CYC);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("ovf_no_sixth", bad, 0);
        chk("ovf_sticky", overflow, 1'b1);

        // Asynchronous reset in the middle of byte 3
        push(vecs[1].pc, vecs[1].instr, vecs[1].a0, vecs[1].miss);
        idle();
        bad = 0;
        while (tx !== 1'b0 && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        chk("mid_start_seen", tx, 1'b0);
        repeat (30 * CLK_DIV + 5) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("mid_reset_out", {tx, busy, overflow}, 3'b100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            begin
                push(vecs[0].pc, vecs[0].instr, vecs[0].a0, vecs[0].miss);
                idle();
            end
            recv_frame(f, ok, det);
        join
        chk("post_reset_frame", f, vecs[0].exp);
        chk("post_reset_framing", ok, 1'b1);
        wait_idle("post_reset_len", det, FRAME_CYC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_trace_tx.md
# sr_trace_tx

Hardware trace transmitter for the schoolRISCV core. It samples the per-instruction debug view that the simulation bench prints: pc, instruction word, register a0 and the branch-miss flag. Samples are buffered in a small FIFO and sent off-chip as fixed-length UART frames, so a host can rebuild the same cycle log from silicon. It sits beside `sm_top` and is fed by the `sm_cpu` debug signals.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥ 2.
- `CLK_DIV`, default 16: clock cycles per UART bit. Must be ≥ 2.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: reset. Asynchronous, active-high.
- `trcValid`  in  1: one sample offered this cycle.
- `trcPc`  in  32: program counter of the sample.
- `trcInstr`  in  32: instruction word of the sample.
- `trcA0`  in  32: value of register x10 (a0).
- `trcMiss`  in  1: branch miss in this cycle (`pcSrc && vld_D`).
- `tx`  out  1: UART line, 8N1, LSB first, idle high.
- `busy`  out  1: FIFO non-empty or a frame in flight.
- `overflow`  out  1: sticky; set when any sample has been dropped.

## Operation
- FIFO entry is 97 bits: {miss, a0, instr, pc}.
- Push occurs on an edge where `trcValid` = 1 and the registered count < DEPTH.
- With count == DEPTH the sample is dropped, even if a pop happens on the same edge.
- On a drop, `dropPending` and `overflow` are set.
- A push and a pop on the same edge are both legal when count < DEPTH; count is then unchanged.
- Serializer FSM has two states, IDLE and SEND.
  - IDLE → SEND on an edge where the FIFO is non-empty. That edge pops the head entry and loads the frame.
  - SEND → IDLE at the end of the last stop bit when the FIFO is empty.
  - If the FIFO is non-empty at that point, the FSM pops again on the same edge and stays in SEND.
- Frame is 14 bytes, in this order:
  - sync 0xA5;
  - pc, little-endian (4 bytes);
  - instr, little-endian (4 bytes);
  - a0, little-endian (4 bytes);
  - flags.
- Flags byte: bit0 = miss, bit1 = `dropPending` value at pop time, bits 7:2 = 0.
- `dropPending` clears on pop, unless a drop occurs on that same edge; then it stays 1.
- Each byte on the wire is a start bit (0), 8 data bits LSB first, and a stop bit (1).
- Bit counter counts 0..CLK_DIV-1; byte index counts 0..13 and bit index 0..9.
- `overflow` clears only by `rst`.
- `busy` is combinational: (count != 0) || (state == SEND).

## Timing
- Reset values: `tx` = 1, `busy` = 0, `overflow` = 0; FIFO empty; `dropPending` = 0; state IDLE.
- Reset takes effect asynchronously, including mid-frame: `tx` goes to 1 at once and the partial frame is abandoned.
- `tx` is registered.
- Latency, sample at edge k with FIFO empty and FSM IDLE:
  - pop occurs at edge k+1;
  - start bit appears on `tx` after edge k+1;
  - each bit is held for exactly CLK_DIV cycles.
- Frame length is 140·CLK_DIV cycles. Consecutive frames have no idle gap: the next start bit directly follows the stop bit.
- Sustained throughput is one sample per 140·CLK_DIV cycles. Faster input overflows after DEPTH (+1 in flight) samples.

## Test plan
- Reset: hold `rst` for 3 cycles → `tx` = 1, `busy` = 0, `overflow` = 0 during and after reset. No traffic appears with `trcValid` = 0 for 1000 cycles.
- Single sample, CLK_DIV = 4: pc = 0x00000010, instr = 0x00500513, a0 = 5, miss = 0 → bytes A5 10 00 00 00 13 05 50 00 05 00 00 00 00. Start bit appears after the 2nd edge. `busy` drops after 560 cycles.
- Miss: same sample with miss = 1 → flags byte 0x01, all other bytes unchanged.
- Overflow, DEPTH = 4: 6 valid samples on consecutive edges → samples 1–5 sent and sample 6 dropped. `overflow` = 1 from the 6th edge. Frame 2 flags = 0x02; frames 1, 3, 4, 5 flags = 0x00.
- Back-to-back: 2 samples → two frames contiguous, 1120 cycles total at CLK_DIV = 4, no high gap beyond the stop bits.
- Reset mid-frame: assert `rst` during byte 3 → `tx` = 1 and `busy` = 0 immediately. After release, one new sample produces a complete frame starting with 0xA5 and flags 0x00.
